// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared AXI-Stream width-converter types and byte-select helper
// Purpose: default input width, drain state encoding and the one-hot
//          lowest/highest-set-bit byte selector shared with the 8-to-32 packer.
// Ports:   none (package).
package axis_pkg;

  localparam int IN_BYTES_DEF = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  // One-hot select of the next byte to emit: lowest set bit when
  // msb_first=0, highest set bit when msb_first=1. Zero mask gives zero.
  function automatic logic [3:0] byte_sel(input logic [3:0] mask, input logic msb_first);
    logic [3:0] sel;
    sel = '0;
    if (msb_first) begin
      for (int i = 0; i < 4; i++)
        if (mask[i]) sel = 4'b0001 << i;
    end else begin
      for (int i = 3; i >= 0; i--)
        if (mask[i]) sel = 4'b0001 << i;
    end
    return sel;
  endfunction

endpackage

// File: rtl/axis_32to8_if.sv
// rtl/axis_32to8_if.sv - stream bundle for the 32-to-8 down-converter
// Purpose: groups the 32-bit input stream, the 8-bit output stream and the
//          null-tlast drop pulse.
// Modports: master = upstream source / downstream sink side,
//           slave  = converter side.
interface axis_32to8_if;
  import axis_pkg::*;

  logic [8*IN_BYTES_DEF-1:0] axis_tdata_in;
  logic [IN_BYTES_DEF-1:0]   axis_tkeep_in;
  logic                      axis_tvalid_in;
  logic                      axis_tlast_in;
  logic                      axis_tready_out;
  logic [7:0]                axis_tdata_out;
  logic                      axis_tvalid_out;
  logic                      axis_tlast_out;
  logic                      axis_tready_in;
  logic                      null_last_drop;

  modport master (
    output axis_tdata_in, axis_tkeep_in, axis_tvalid_in, axis_tlast_in, axis_tready_in,
    input  axis_tready_out, axis_tdata_out, axis_tvalid_out, axis_tlast_out, null_last_drop
  );

  modport slave (
    input  axis_tdata_in, axis_tkeep_in, axis_tvalid_in, axis_tlast_in, axis_tready_in,
    output axis_tready_out, axis_tdata_out, axis_tvalid_out, axis_tlast_out, null_last_drop
  );

endinterface

// File: rtl/axis_byte_pick.sv
// rtl/axis_byte_pick.sv - priority select of the next byte lane from a keep mask
// Purpose: combinational pick of the lowest (MSB_FIRST=0) or highest
//          (MSB_FIRST=1) pending byte.
// Ports:   mask_i pending-byte mask, sel_o one-hot lane, idx_o lane index.
module axis_byte_pick
  import axis_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [3:0] mask_i,
  output logic [3:0] sel_o,
  output logic [1:0] idx_o
);

  assign sel_o = byte_sel(mask_i, MSB_FIRST);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < 4; i++)
      if (sel_o[i]) idx_o = 2'(i);
  end

endmodule

// File: rtl/axis_32to8.sv
// rtl/axis_32to8.sv - AXI4-Stream 32-bit to 8-bit down-converter with tkeep skipping
// Purpose: serialises kept bytes of each input word, moves tlast to the last
//          kept byte, pulses null_last_drop on a tlast word with no kept bytes.
// Ports:   clk, reset_n (async active-low); s = stream bundle (slave modport).
module axis_32to8
  import axis_pkg::*;
#(
  parameter int IN_BYTES  = IN_BYTES_DEF,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  axis_32to8_if.slave   s
);

  logic [8*IN_BYTES-1:0] word_q, word_d;
  logic [IN_BYTES-1:0]   mask_q, mask_d;
  logic                  last_q, last_d;
  logic                  drop_q, drop_d;

  drain_state_e state;
  logic [3:0]   sel;
  logic [1:0]   idx;
  logic         final_byte;
  logic         tvalid;
  logic         tready;
  logic         in_fire;
  logic         out_fire;

  axis_byte_pick #(.MSB_FIRST(MSB_FIRST)) u_pick (
    .mask_i (mask_q),
    .sel_o  (sel),
    .idx_o  (idx)
  );

  // The pending mask is the whole state: any bit left means we are draining.
  assign state      = (mask_q != '0) ? ST_DRAIN : ST_EMPTY;
  assign final_byte = $onehot(mask_q);
  assign tvalid     = (state == ST_DRAIN);
  // Accept the next word in the same cycle the final byte leaves, so words
  // stream back to back without a bubble.
  assign tready     = (state == ST_EMPTY) | (final_byte & s.axis_tready_in);
  assign in_fire    = s.axis_tvalid_in & tready;
  assign out_fire   = tvalid & s.axis_tready_in;

  assign s.axis_tvalid_out = tvalid;
  assign s.axis_tready_out = tready;
  assign s.axis_tdata_out  = word_q[8*idx +: 8];
  assign s.axis_tlast_out  = last_q & final_byte;
  assign s.null_last_drop  = drop_q;

  always_comb begin
    word_d = word_q;
    mask_d = mask_q;
    last_d = last_q;
    drop_d = 1'b0;
    if (out_fire)
      mask_d = mask_q & ~sel;
    // A new word overrides the bit clear of the byte leaving this cycle.
    if (in_fire) begin
      word_d = s.axis_tdata_in;
      mask_d = s.axis_tkeep_in;
      last_d = s.axis_tlast_in;
      drop_d = s.axis_tlast_in & (s.axis_tkeep_in == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      word_q <= word_d;
      mask_q <= mask_d;
      last_q <= last_d;
      drop_q <= drop_d;
    end
  end

endmodule
